// File: rtl/bound_flasher_seq.sv
// LED bound-flasher sequencer: state register, step counter, tick prescaler
// and thermometer LED decode. Sequence 0 -> NUM_LEDS -> L1 -> P2 -> 0 -> P3 -> 0.
module bound_flasher_seq #(
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned L1       = 5,
  parameter int unsigned P2       = 10,
  parameter int unsigned P3       = 5,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = $clog2(NUM_LEDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flick,
  input  logic                loop_en,
  output logic [NUM_LEDS-1:0] led,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UP1  = 3'd1;
  localparam logic [2:0] S_DN1  = 3'd2;
  localparam logic [2:0] S_UP2  = 3'd3;
  localparam logic [2:0] S_DN2  = 3'd4;
  localparam logic [2:0] S_UP3  = 3'd5;
  localparam logic [2:0] S_DN3  = 3'd6;

  localparam logic [CNT_W-1:0] PK1 = CNT_W'(NUM_LEDS);
  localparam logic [CNT_W-1:0] FL1 = CNT_W'(L1);
  localparam logic [CNT_W-1:0] PK2 = CNT_W'(P2);
  localparam logic [CNT_W-1:0] PK3 = CNT_W'(P3);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             active;

  assign tick   = (div == DIV_LAST);
  assign active = (state != S_IDLE) && (state != 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      div   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active)
        div <= tick ? '0 : div + 1'b1;
      else
        div <= '0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (flick) state <= S_UP1;
        end
        S_UP1: if (tick) begin
          if (cnt == PK1) state <= S_DN1;
          else            cnt   <= cnt + 1'b1;
        end
        // At a DN floor, flick reloads the previous peak instead of turning.
        S_DN1: if (tick) begin
          if (cnt != FL1) cnt   <= cnt - 1'b1;
          else if (flick) cnt   <= PK1;
          else            state <= S_UP2;
        end
        S_UP2: if (tick) begin
          if (cnt == PK2) state <= S_DN2;
          else            cnt   <= cnt + 1'b1;
        end
        S_DN2: if (tick) begin
          if (cnt != '0)  cnt   <= cnt - 1'b1;
          else if (flick) cnt   <= PK2;
          else            state <= S_UP3;
        end
        S_UP3: if (tick) begin
          if (cnt == PK3) state <= S_DN3;
          else            cnt   <= cnt + 1'b1;
        end
        S_DN3: if (tick) begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            done  <= 1'b1;
            state <= loop_en ? S_UP1 : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    led = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++)
      led[i] = (CNT_W'(i) < cnt);
  end

  assign phase = state;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_bound_flasher_seq.sv
// Directed bench for bound_flasher_seq: default instance plus a small
// TICK_DIV=3 instance; expectations are hand-derived edge numbers.
module tb_bound_flasher_seq;

  logic        clk = 1'b0;
  logic        rst, flick, loop_en, flick2;
  logic [15:0] led;
  logic [2:0]  phase;
  logic        busy, done;
  logic [7:0]  led2;
  logic [2:0]  phase2;
  logic        busy2, done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bound_flasher_seq dut (
    .clk(clk), .rst(rst), .flick(flick), .loop_en(loop_en),
    .led(led), .phase(phase), .busy(busy), .done(done)
  );

  bound_flasher_seq #(
    .NUM_LEDS(8), .L1(2), .P2(6), .P3(3), .TICK_DIV(3)
  ) dut2 (
    .clk(clk), .rst(rst), .flick(flick2), .loop_en(1'b0),
    .led(led2), .phase(phase2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Start a sequence: flick sampled at the next edge (E0).
  task automatic start_seq();
    flick = 1'b1;
    edge1();
    flick = 1'b0;
  endtask

  initial begin
    int done_cnt, busy_low, bad_step;
    logic [7:0] prev2;

    rst = 1'b1; flick = 1'b0; loop_en = 1'b0; flick2 = 1'b0;
    edge1(); edge1();
    chk("reset_led",   {16'h0, led}, 32'h0);
    chk("reset_phase", {29'h0, phase}, 32'h0);
    chk("reset_busy",  {31'h0, busy}, 32'h0);
    chk("reset_done",  {31'h0, done}, 32'h0);
    rst = 1'b0;

    // Reset mid-UP1
    start_seq();
    chk("start_phase", {29'h0, phase}, 32'd1);
    chk("start_busy",  {31'h0, busy}, 32'd1);
    chk("start_led",   {16'h0, led}, 32'h0);
    repeat (8) edge1();
    chk("mid_up1_led", {16'h0, led}, 32'h00FF);
    rst = 1'b1; flick = 1'b1;
    edge1();
    chk("rst_mid_led",   {16'h0, led}, 32'h0);
    chk("rst_mid_phase", {29'h0, phase}, 32'h0);
    chk("rst_mid_busy",  {31'h0, busy}, 32'h0);
    chk("rst_mid_done",  {31'h0, done}, 32'h0);
    rst = 1'b0; flick = 1'b0;
    edge1();
    chk("post_rst_idle", {29'h0, phase}, 32'h0);

    // Full sequence, no kickback
    start_seq();
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      edge1();
      if (done) done_cnt++;
      if (k == 17) begin chk("full_peak1", {16'h0, led}, 32'hFFFF); chk("full_ph17", {29'h0, phase}, 32'd2); end
      if (k == 29) begin chk("full_floor1", {16'h0, led}, 32'h001F); chk("full_ph29", {29'h0, phase}, 32'd3); end
      if (k == 35) begin chk("full_peak2", {16'h0, led}, 32'h03FF); chk("full_ph35", {29'h0, phase}, 32'd4); end
      if (k == 46) begin chk("full_floor2", {16'h0, led}, 32'h0); chk("full_ph46", {29'h0, phase}, 32'd5); end
      if (k == 52) begin chk("full_peak3", {16'h0, led}, 32'h001F); chk("full_ph52", {29'h0, phase}, 32'd6); end
      if (k == 57) chk("full_done57", {31'h0, done}, 32'd0);
      if (k == 58) begin chk("full_done58", {31'h0, done}, 32'd1); chk("full_busy58", {31'h0, busy}, 32'd0); end
      if (k == 59) chk("full_done59", {31'h0, done}, 32'd0);
    end
    chk("full_done_count", done_cnt, 32'd1);

    // Kickback in DN1
    start_seq();
    done_cnt = 0;
    for (int k = 1; k <= 72; k++) begin
      edge1();
      if (done) done_cnt++;
      if (k == 28) begin chk("kb1_floor", {16'h0, led}, 32'h001F); flick = 1'b1; end
      if (k == 29) begin chk("kb1_led", {16'h0, led}, 32'hFFFF); chk("kb1_phase", {29'h0, phase}, 32'd2); flick = 1'b0; end
      if (k == 69) chk("kb1_done69", {31'h0, done}, 32'd0);
      if (k == 70) chk("kb1_done70", {31'h0, done}, 32'd1);
    end
    chk("kb1_done_count", done_cnt, 32'd1);

    // Two DN2 kickbacks, then flick high through DN3 floor
    start_seq();
    for (int k = 1; k <= 81; k++) begin
      edge1();
      if (k == 45) begin chk("kb2_floor_a", {16'h0, led}, 32'h0); flick = 1'b1; end
      if (k == 46) begin chk("kb2_reload_a", {16'h0, led}, 32'h03FF); chk("kb2_ph46", {29'h0, phase}, 32'd4); end
      if (k == 56) chk("kb2_floor_b", {16'h0, led}, 32'h0);
      if (k == 57) begin chk("kb2_reload_b", {16'h0, led}, 32'h03FF); chk("kb2_ph57", {29'h0, phase}, 32'd4); flick = 1'b0; end
      if (k == 68) begin chk("kb2_up3", {29'h0, phase}, 32'd5); flick = 1'b1; end
      if (k == 79) begin chk("kb2_dn3_ph", {29'h0, phase}, 32'd6); chk("kb2_done79", {31'h0, done}, 32'd0); end
      if (k == 80) begin chk("kb2_done80", {31'h0, done}, 32'd1); chk("kb2_idle80", {29'h0, phase}, 32'd0); flick = 1'b0; end
      if (k == 81) chk("kb2_idle81", {29'h0, phase}, 32'd0);
    end

    // Loop mode: one restart, then back to IDLE
    loop_en = 1'b1;
    start_seq();
    busy_low = 0;
    for (int k = 1; k <= 117; k++) begin
      edge1();
      if (k < 116 && !busy) busy_low++;
      if (k == 58) begin
        chk("loop_done58", {31'h0, done}, 32'd1);
        chk("loop_ph58", {29'h0, phase}, 32'd1);
        chk("loop_led58", {16'h0, led}, 32'h0);
        loop_en = 1'b0;
      end
      if (k == 116) begin chk("loop_done116", {31'h0, done}, 32'd1); chk("loop_ph116", {29'h0, phase}, 32'd0); end
    end
    chk("loop_busy_held", busy_low, 32'd0);

    // Parameter sweep instance, TICK_DIV=3
    flick2 = 1'b1;
    edge1();
    flick2 = 1'b0;
    prev2 = led2;
    bad_step = 0;
    done_cnt = 0;
    for (int k = 1; k <= 110; k++) begin
      edge1();
      if (led2 != prev2 && (k % 3) != 0) bad_step++;
      prev2 = led2;
      if (done2) done_cnt++;
      if (k == 2)   chk("sw_led2", {24'h0, led2}, 32'h00);
      if (k == 3)   chk("sw_led3", {24'h0, led2}, 32'h01);
      if (k == 6)   chk("sw_led6", {24'h0, led2}, 32'h03);
      if (k == 24)  begin chk("sw_peak", {24'h0, led2}, 32'hFF); chk("sw_ph24", {29'h0, phase2}, 32'd1); end
      if (k == 27)  chk("sw_ph27", {29'h0, phase2}, 32'd2);
      if (k == 107) chk("sw_done107", {31'h0, done2}, 32'd0);
      if (k == 108) begin chk("sw_done108", {31'h0, done2}, 32'd1); chk("sw_busy108", {31'h0, busy2}, 32'd0); end
    end
    chk("sw_step_rate", bad_step, 32'd0);
    chk("sw_done_count", done_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bound_flasher_seq.md
# bound_flasher_seq

Parametrised LED bound-flasher sequencer with state register, step counter, tick prescaler and thermometer LED decode in one block. Successor to the fixed 16-LED next-state generator. The 0→NUM_LEDS→L1→P2→0→P3→0 sequence is generalised in width and bounds, the kickback is detected internally from `flick`, and it adds step-rate division, loop mode and completion status. It sits between the `flick` button synchroniser and the LED pads.

## Interface
- `NUM_LEDS`, 16: LED count and first peak (P1); ≥ 2.
- `L1`, 5: floor of first down phase; kickback point 1; 0 < L1 < NUM_LEDS.
- `P2`, 10: peak of second up phase; L1 < P2 ≤ NUM_LEDS.
- `P3`, 5: peak of third up phase; 0 < P3 ≤ NUM_LEDS.
- `TICK_DIV`, 1: clock cycles per sequence step; ≥ 1.
- `CNT_W`, $clog2(NUM_LEDS+1): counter width; derived, not overridden.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flick`  in  1  start request / kickback request; already synchronised.
- `loop_en`  in  1  sampled at end of sequence; 1 = restart without returning to IDLE.
- `led`  out  NUM_LEDS  thermometer: led[i] = (i < cnt).
- `phase`  out  3  current state encoding.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- State encodings (`phase`): IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6. Value 7 is unreachable; if entered, next state is IDLE with cnt=0.
- Registers: state, cnt[CNT_W-1:0], div[$clog2(TICK_DIV)..0], done. All of them are cleared by rst: state=IDLE, cnt=0, div=0, done=0. Therefore led=0, busy=0, phase=0.
- rst has priority over every other event, including mid-sequence. There is no partial completion and no done pulse.
- IDLE: div held 0, cnt held 0. On `flick`=1 at an edge, the next state is UP1. `loop_en` is ignored here.
- Prescaler, active states only: tick = (div == TICK_DIV-1). div wraps to 0 on tick, otherwise increments. State and cnt change only on tick edges.
- Per tick, UP states (peak: UP1=NUM_LEDS, UP2=P2, UP3=P3):
  - cnt == peak: go to the following DN state; cnt unchanged.
  - Otherwise: cnt+1.
- Per tick, DN states (floor: DN1=L1, DN2=0, DN3=0):
  - cnt != floor: cnt-1.
  - DN1, cnt==L1, flick=1: kickback. cnt←NUM_LEDS, stay DN1.
  - DN1, cnt==L1, flick=0: go to UP2.
  - DN2, cnt==0, flick=1: kickback. cnt←P2, stay DN2.
  - DN2, cnt==0, flick=0: go to UP3.
  - DN3, cnt==0: done←1. Next state is UP1 if loop_en=1, else IDLE. No kickback in DN3.
- `flick` is ignored at non-tick edges, in UP states, and in DN states when cnt != floor.
- cnt never underflows or exceeds NUM_LEDS. Arithmetic is unsigned at CNT_W.
- done is a registered pulse, otherwise 0.

## Timing
- Start: with flick sampled at edge E0, phase=1 and busy=1 from E0+. led remains 0 until the first UP1 tick.
- Each turn (peak/floor reached) consumes one tick with cnt held.
- Default parameters, TICK_DIV=1, no kickback: 58 ticks after E0. Breakdown: UP1 17, DN1 12, UP2 6, DN2 11, UP3 6, DN3 6.
  - done=1 during the cycle after E58 only.
  - busy=0 from E58+, unless loop_en=1.
- Generic no-kickback tick count: (NUM_LEDS+1) + (NUM_LEDS-L1+1) + (P2-L1+1) + (P2+1) + (P3+1) + (P3+1). Multiply by TICK_DIV for cycles.
- Kickback adds (NUM_LEDS-L1+1) ticks per DN1 kick and (P2+1) per DN2 kick. Repeated kicks are unlimited.
- Outputs led/phase/busy are decoded from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Reset mid-UP1 (defaults): pulse flick, run 8 cycles, assert rst for 1 cycle. Next edge gives led=0, phase=0, busy=0, done=0. flick held high during rst → still IDLE.
- Full sequence (defaults, TICK_DIV=1): single flick pulse. Check:
  - led peaks at 16'hFFFF, then falls to 16'h001F, rises to 16'h03FF, falls to 0, rises to 16'h001F, falls to 0.
  - done pulses exactly once, 58 cycles after the flick edge.
- Kickback DN1: flick=1 on the tick where cnt==5 in DN1 → cnt=16, phase=2 next edge. done is delayed to 70 cycles.
- Kickback DN2 twice plus DN3 immunity: flick held high through DN2 floor and DN3 → cnt reloads to 10 at each DN2 floor tick (sequence never leaves DN2 while flick=1). Release flick → completes; DN3 has no kickback.
- Loop mode: loop_en=1 → at DN3 cnt==0, done=1 and phase=1 on the same edge; busy never drops. loop_en=0 on the second pass → IDLE.
- Parameter sweep: NUM_LEDS=8, L1=2, P2=6, P3=3, TICK_DIV=3 → cnt changes only every 3rd cycle. done at 3×(9+7+5+7+4+4)=108 cycles.
